// File: rtl/nios_system_sw_pio_in.sv
// nios_system_sw_pio_in: Avalon-MM switch/button input port with sync, debounce (NIOS_SYSTEM_SW_PIO_DEBOUNCE_EN), edge capture and irq
module nios_system_sw_pio_in #(
  parameter int WIDTH = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] s1_q, s2_q, data, data_dly_q, mask_q, mask_d, cap_q, cap_d, edges, rd;
  logic wr, unused_wd;
  assign unused_wd = ^writedata;
`ifdef NIOS_SYSTEM_SW_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];
  assign data = data_q;
  always_comb begin
    data_d = data_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      data_d[i] = (s2_q[i] != data_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? s2_q[i] : data_q[i];
      cnt_d[i] = (s2_q[i] == data_q[i] || cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt_q[i] + CW'(1);
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      data_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
`else
  assign data = s2_q;
`endif
  always_comb begin
    wr = chipselect & ~write_n;
    edges = EDGE_TYPE == 0 ? data & ~data_dly_q :
            EDGE_TYPE == 1 ? ~data & data_dly_q : data ^ data_dly_q;
    mask_d = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
    cap_d = (cap_q & ~((wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0)) | edges;
    rd = address == 2'd0 ? data : address == 2'd2 ? mask_q : address == 2'd3 ? cap_q : '0;
    readdata = 32'(rd);
    irq = |(cap_q & mask_q);
  end
  always_ff @(posedge clk)
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      data_dly_q <= '0;
      mask_q <= '0;
      cap_q <= '0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
      data_dly_q <= data;
      mask_q <= mask_d;
      cap_q <= cap_d;
    end
endmodule

// File: tb/tb_nios_system_sw_pio_in.sv
// tb_nios_system_sw_pio_in: directed table-driven bench; expectations follow NIOS_SYSTEM_SW_PIO_DEBOUNCE_EN
module tb_nios_system_sw_pio_in;
`ifdef NIOS_SYSTEM_SW_PIO_DEBOUNCE_EN
  localparam int LAT = 5;
  localparam bit DEB = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit DEB = 1'b0;
`endif
  logic clk = 0, reset = 1, chipselect = 0, write_n = 1, irq, irq2;
  logic [1:0] address = 0;
  logic [31:0] writedata = 0, readdata, readdata2;
  logic [9:0] in_port = 0;
  int n_cmp = 0, n_bad = 0;
  typedef struct { logic [9:0] in; logic [31:0] exp_data; logic [31:0] exp_cap; logic exp_irq; } vec_t;
  vec_t vecs [8];
  always #10 clk = ~clk;
  nios_system_sw_pio_in #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(readdata), .irq(irq));
  nios_system_sw_pio_in #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(readdata2), .irq(irq2));
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1 chk(nm, readdata, exp);
  endtask
  task automatic rd2(input string nm, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1 chk(nm, readdata2, exp);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    tick();
    chipselect = 0; write_n = 1; writedata = 0;
  endtask
  initial begin
    for (int k = 0; k < 8; k++)
      vecs[k] = '{10'h001, (k >= LAT) ? 32'h1 : 32'h0, (k >= LAT + 1) ? 32'h1 : 32'h0, 1'b0};
    repeat (3) tick();
    reset = 0;
    rd("rst_a0", 0, 0); rd("rst_a1", 1, 0); rd("rst_a2", 2, 0); rd("rst_a3", 3, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    for (int k = 0; k < 8; k++) begin
      in_port = vecs[k].in;
      tick();
      rd($sformatf("rise_data_e%0d", k), 0, vecs[k].exp_data);
      rd($sformatf("rise_cap_e%0d", k), 3, vecs[k].exp_cap);
      chk($sformatf("rise_irq_e%0d", k), {31'd0, irq}, {31'd0, vecs[k].exp_irq});
    end
    wr(0, 32'h3FF);
    wr(1, 32'h3FF);
    rd("data_ro", 0, 32'h1);
    rd("rsvd_ro", 1, 0);
    wr(2, 32'hFFFF_F001);
    chk("mask_irq", {31'd0, irq}, 1);
    rd("mask_rd", 2, 32'h1);
    in_port = 10'h009;
    repeat (3) tick();
    in_port = 10'h001;
    repeat (8) tick();
    rd("glitch_data", 0, 32'h1);
    rd("glitch_cap", 3, DEB ? 32'h1 : 32'h9);
    wr(3, 32'h008);
    rd("w1c_bit3", 3, 32'h1);
    wr(3, 32'h001);
    rd("clr_cap", 3, 0);
    chk("clr_irq", {31'd0, irq}, 0);
    in_port = 10'h000;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == LAT) rd2("fall_any_pre", 3, 0);
      if (k == LAT + 1) rd2("fall_any_set", 3, 32'h1);
    end
    rd("fall_rise_cap", 3, 0);
    chk("fall_rise_irq", {31'd0, irq}, 0);
    wr(3, 32'h3FF);
    in_port = 10'h001;
    for (int k = 0; k <= LAT; k++) tick();
    rd("race_pre", 3, 0);
    wr(3, 32'h001);
    rd("race_cap", 3, 32'h1);
    chk("race_irq", {31'd0, irq}, 1);
    in_port = 10'h2A5;
    repeat (2) tick();
    rd("fast_data", 0, DEB ? 32'h001 : 32'h2A5);
    repeat (8) tick();
    rd("settled_data", 0, 32'h2A5);
    in_port = 10'h0A5;
    repeat (8) tick();
    wr(3, 32'h3FF);
    rd("pre_pulse_cap", 3, 0);
    in_port = 10'h2A5;
    tick();
    in_port = 10'h0A5;
    repeat (8) tick();
    rd("pulse9_cap", 3, DEB ? 32'h0 : 32'h200);
    rd("pulse9_data", 0, 32'h0A5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
